mips_write_buffer: RTL
======================

Name: mips_write_buffer

Overview:
- Posted-write FIFO between the cache controller's store path and the Avalon bus master port.
- Accepts CPU stores in one cycle, merges same-word stores into the youngest entry, and drains entries to memory when the controller grants the bus.
- Its `empty` output is the controller's `wb_empty_out`; it keeps the top-level `active` high until all stores retire.

Parameters:
- DEPTH, 4, number of entries; power of two, at least 2.
- PTR_W, 2, log2(DEPTH); width of the read/write pointers.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- push_valid  input  1  store request from the cache controller.
- push_address  input  32  store byte address; bits [1:0] are ignored.
- push_data  input  32  store data, lane-aligned.
- push_byteenable  input  4  byte lanes written.
- push_ready  output  1  the store is accepted this cycle if push_valid=1.
- lookup_address  input  32  read address probed by the controller.
- lookup_hit  output  1  a valid entry, including the in-flight one, holds word lookup_address[31:2].
- mem_grant  input  1  the controller allows a drain to start this cycle.
- mem_address  output  32  Avalon address, word-aligned ({addr[31:2],2'b00}).
- mem_write  output  1  Avalon write.
- mem_writedata  output  32  Avalon write data.
- mem_byteenable  output  4  Avalon byte enables.
- waitrequest  input  1  Avalon waitrequest.
- empty  output  1  no valid entries.
- count  output  PTR_W+1  number of valid entries, 0..DEPTH.

Behaviour:
- Reset (async, immediate): count=0, pointers=0, state=IDLE.
  - Outputs: empty=1, push_ready=1, mem_write=0, mem_address/mem_writedata/mem_byteenable=0, lookup_hit=0.
  - Reset during a bus write drops mem_write at once and discards all entries.
- Entry contents: word address [31:2], data[31:0], be[3:0].
- FSM states:
  - IDLE:
    - Bus outputs are 0.
    - If count>0 and mem_grant=1, go to WRITE on the next edge, latching the head entry as in-flight.
  - WRITE:
    - mem_write=1; mem_address, mem_writedata and mem_byteenable come from the head entry and are held stable.
    - mem_grant is ignored while in WRITE.
    - Completion is a rising edge with waitrequest=0: pop the head (rd_ptr+1, count-1) and go to IDLE.
    - IDLE is always visited for one cycle between writes, giving the controller a slot for reads.
- Merge condition: push_valid=1 and count>0 and push_address[31:2] equals the tail entry's address, and the tail is not in flight (not (state=WRITE and count=1)).
  - On merge, bytes whose push_byteenable bit is 1 overwrite the tail's data; tail be |= push_byteenable; count is unchanged.
- Otherwise, an accepted push writes a new entry at wr_ptr, then wr_ptr+1 and count+1.
- Pointers wrap modulo DEPTH.
- push_ready = (count<DEPTH) or merge condition. It depends on registered count only, so a push and a pop in the same cycle when full gives push_ready=0.
- A push while push_ready=0 is ignored with no state change; the controller must stall the CPU.
- Simultaneous push (non-merge) and pop: count unchanged, both pointers advance.
- Simultaneous merge and pop: legal only when the tail is not the head; both happen.
- lookup_hit is combinational over all valid entries. The controller stalls reads that hit until the entry drains; no data forwarding.
- empty = (count==0). A store is in the buffer until its Avalon write completes.
- Latency:
  - Push to mem_write with mem_grant=1 and the buffer empty: 2 cycles (entry written at edge 1, WRITE entered at edge 2).
  - With waitrequest=0, one write per 2 cycles.

Test Plan:
- Reset, then push 0x100/0xDEADBEEF/be=F with grant=1, waitrequest=0 -> mem_write=1 for exactly 1 cycle with address 0x100, data 0xDEADBEEF; then empty=1, count=0.
- Push 0x200 be=0001 data 0x000000AA, then 0x202 be=0100 data 0x00CC0000, with grant=0 -> count=1; after grant, one write of data 0x00CC00AA, be=0101.
- Fill DEPTH=4 entries with grant=0 -> push_ready=0; a 5th distinct-address push is ignored and count stays 4; a same-word push to the tail is accepted (merge).
- Grant with waitrequest held high 5 cycles -> mem_write and address/data stable for 6 cycles; pop only on the waitrequest=0 edge; lookup_hit=1 for the in-flight address throughout.
- Push 5 stores interleaved with drains so wr_ptr wraps -> memory sees all 5 in push order with correct data.
- Assert rst while in WRITE with waitrequest=1 -> mem_write=0 in the same cycle; empty=1, count=0.

Source files
------------

// File: rtl/mips_write_buffer.sv
// Posted-write FIFO between the cache controller's store path and the Avalon master.
// Same-word stores merge into the youngest entry; entries drain one Avalon write at a time.
module mips_write_buffer #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_valid,
    input  logic [31:0]      push_address,
    input  logic [31:0]      push_data,
    input  logic [3:0]       push_byteenable,
    output logic             push_ready,
    input  logic [31:0]      lookup_address,
    output logic             lookup_hit,
    input  logic             mem_grant,
    output logic [31:0]      mem_address,
    output logic             mem_write,
    output logic [31:0]      mem_writedata,
    output logic [3:0]       mem_byteenable,
    input  logic             waitrequest,
    output logic             empty,
    output logic [PTR_W:0]   count
);

    typedef enum logic {
        IDLE  = 1'b0,
        WRITE = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [29:0]        addr_q [DEPTH];
    logic [31:0]        data_q [DEPTH];
    logic [3:0]         be_q   [DEPTH];
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   tail_ptr;
    logic [PTR_W-1:0]   offset;
    logic [PTR_W:0]     count_q, count_d;
    logic               merge;
    logic               push_accept;
    logic               push_new;
    logic               pop;
    logic               unused_addr_bits;

    // Byte offsets are irrelevant: entries are tracked per word.
    assign unused_addr_bits = ^{push_address[1:0], lookup_address[1:0]};

    // The head entry is being written on the bus when WRITE holds the only entry,
    // so merging into it then would change data mid-transfer.
    assign tail_ptr    = wr_ptr_q - PTR_W'(1);
    assign merge       = push_valid && (count_q != '0)
                         && (push_address[31:2] == addr_q[tail_ptr])
                         && !((state_q == WRITE) && (count_q == (PTR_W+1)'(1)));
    assign push_ready  = (count_q < (PTR_W+1)'(DEPTH)) || merge;
    assign push_accept = push_valid && push_ready;
    assign push_new    = push_accept && !merge;
    assign empty       = (count_q == '0);
    assign count       = count_q;

    always_comb begin
        state_d        = state_q;
        pop            = 1'b0;
        mem_write      = 1'b0;
        mem_address    = '0;
        mem_writedata  = '0;
        mem_byteenable = '0;
        case (state_q)
            IDLE: begin
                if (!empty && mem_grant) begin
                    state_d = WRITE;
                end
            end
            WRITE: begin
                mem_write      = 1'b1;
                mem_address    = {addr_q[rd_ptr_q], 2'b00};
                mem_writedata  = data_q[rd_ptr_q];
                mem_byteenable = be_q[rd_ptr_q];
                if (!waitrequest) begin
                    pop     = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (push_new) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (push_new && !pop) begin
            count_d = count_q + (PTR_W+1)'(1);
        end else if (!push_new && pop) begin
            count_d = count_q - (PTR_W+1)'(1);
        end
    end

    // An entry is live when its distance from the head is below the occupancy.
    always_comb begin
        lookup_hit = 1'b0;
        offset     = '0;
        for (int i = 0; i < DEPTH; i++) begin
            offset = PTR_W'(i) - rd_ptr_q;
            if (({1'b0, offset} < count_q) && (addr_q[i] == lookup_address[31:2])) begin
                lookup_hit = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
                be_q[i]   <= '0;
            end
        end else if (push_new) begin
            addr_q[wr_ptr_q] <= push_address[31:2];
            data_q[wr_ptr_q] <= push_data;
            be_q[wr_ptr_q]   <= push_byteenable;
        end else if (merge) begin
            for (int b = 0; b < 4; b++) begin
                if (push_byteenable[b]) begin
                    data_q[tail_ptr][8*b +: 8] <= push_data[8*b +: 8];
                end
            end
            be_q[tail_ptr] <= be_q[tail_ptr] | push_byteenable;
        end
    end

endmodule
